// File: rtl/mmio_data_mem_if.sv
// Load/store bus between the CPU memory stage and the data memory.
// The master drives one request per cycle; the slave answers one cycle later.
interface mmio_data_mem_if #(
   parameter int ADDR_W = 8
);
   logic [ADDR_W-1:0] address;
   logic              read_en;
   logic              write_en;
   logic [1:0]        byte_en;
   logic [15:0]       input_data;
   logic [15:0]       output_data;
   logic              read_valid;
   logic              access_fault;

   modport master (
      output address, read_en, write_en, byte_en, input_data,
      input  output_data, read_valid, access_fault
   );

   modport slave (
      input  address, read_en, write_en, byte_en, input_data,
      output output_data, read_valid, access_fault
   );
endinterface

// File: rtl/mmio_data_mem.sv
// Byte-addressed data RAM with a 32-byte memory-mapped I/O window.
// 16-bit big-endian accesses; each byte lane decodes independently.
module mmio_data_mem #(
   parameter int ADDR_W  = 8,
   parameter int IO_BASE = 'h40,
   parameter int SW_W    = 16,
   parameter int BTN_W   = 5
) (
   input  logic             CLK,
   input  logic             RST,
   mmio_data_mem_if.slave   bus,
   input  logic [SW_W-1:0]  SW,
   input  logic [BTN_W-1:0] BTNS,
   output logic [31:0]      SSEG_VALUE,
   output logic [15:0]      LED
);
   localparam int BANK_W     = ADDR_W - 1;
   localparam int BANK_DEPTH = 1 << BANK_W;
   localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);

   // Lane 1 is the high byte at address, lane 0 the low byte at address+1.
   logic [1:0][ADDR_W-1:0] lane_addr;
   logic [1:0][4:0]        lane_off;
   logic [1:0][7:0]        lane_wdata;
   logic [1:0][7:0]        lane_io_rd;
   logic [1:0]             lane_io;
   logic [1:0]             lane_ro;
   logic [1:0]             lane_we;
   logic [1:0]             lane_ram_we;
   logic [1:0]             lane_edge_hit;
   logic                   wr_ok;

   logic [SW_W-1:0]  sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
   logic [BTN_W-1:0] btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
   logic [BTN_W-1:0] btn_prev_q, btn_prev_d, btn_edge_q, btn_edge_d;
   logic [31:0]      sseg_q, sseg_d;
   logic [15:0]      led_q, led_d;
   logic             rd_valid_q, rd_valid_d;
   logic             fault_q, fault_d;
   logic [1:0]       rd_io_q, rd_io_d;
   logic [15:0]      rd_io_byte_q, rd_io_byte_d;
   logic             rd_swap_q, rd_swap_d;

   logic [7:0]        ram_even [BANK_DEPTH];
   logic [7:0]        ram_odd  [BANK_DEPTH];
   logic [7:0]        ram_even_rd_q, ram_odd_rd_q;
   logic [BANK_W-1:0] even_idx, odd_idx;
   logic              even_we, odd_we;
   logic [7:0]        even_wdata, odd_wdata;
   logic              a_odd;

   function automatic logic [7:0] io_read(
      input logic [4:0]       off,
      input logic [31:0]      sseg,
      input logic [15:0]      led,
      input logic [SW_W-1:0]  sw,
      input logic [BTN_W-1:0] btn,
      input logic [BTN_W-1:0] edges
   );
      logic [15:0] sw_ext;
      sw_ext = 16'(sw);
      case (off)
         5'h00:   return sseg[31:24];
         5'h01:   return sseg[23:16];
         5'h02:   return sseg[15:8];
         5'h03:   return sseg[7:0];
         5'h04:   return led[15:8];
         5'h05:   return led[7:0];
         5'h0E:   return sw_ext[15:8];
         5'h0F:   return sw_ext[7:0];
         5'h11:   return 8'(btn);
         5'h13:   return 8'(edges);
         default: return 8'h00;
      endcase
   endfunction

   assign wr_ok        = bus.write_en & ~bus.read_en;
   assign lane_addr[1] = bus.address;
   assign lane_addr[0] = bus.address + ADDR_W'(1);
   assign lane_wdata   = bus.input_data;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_lane
         assign lane_io[gi]  = lane_addr[gi][ADDR_W-1:5] == IO_BASE_A[ADDR_W-1:5];
         assign lane_off[gi] = lane_addr[gi][4:0];
         // Synchronised inputs and the edge register (0x0E-0x13) are read-only.
         assign lane_ro[gi]       = lane_io[gi] && (lane_off[gi] >= 5'h0E) && (lane_off[gi] <= 5'h13);
         assign lane_we[gi]       = wr_ok & bus.byte_en[gi];
         assign lane_ram_we[gi]   = lane_we[gi] & ~lane_io[gi] & ~RST;
         assign lane_edge_hit[gi] = bus.read_en & lane_io[gi] & (lane_off[gi] == 5'h13);
         assign lane_io_rd[gi]    = io_read(lane_off[gi], sseg_q, led_q, sw_s2_q, btn_s2_q, btn_edge_q);
      end
   endgenerate

   always_comb begin
      sw_s1_d    = SW;
      sw_s2_d    = sw_s1_q;
      btn_s1_d   = BTNS;
      btn_s2_d   = btn_s1_q;
      btn_prev_d = btn_s2_q;
      // A fresh edge on the clearing edge survives: set has priority over clear.
      btn_edge_d = (btn_edge_q & ~{BTN_W{|lane_edge_hit}}) | (btn_s2_q & ~btn_prev_q);

      sseg_d = sseg_q;
      led_d  = led_q;
      for (int ln = 0; ln < 2; ln++) begin
         if (lane_we[ln] && lane_io[ln]) begin
            for (int k = 0; k < 4; k++) begin
               if (lane_off[ln] == 5'(k)) begin
                  sseg_d[31-8*k -: 8] = lane_wdata[ln];
               end
            end
            if (lane_off[ln] == 5'h04) begin
               led_d[15:8] = lane_wdata[ln];
            end
            if (lane_off[ln] == 5'h05) begin
               led_d[7:0] = lane_wdata[ln];
            end
         end
      end

      rd_valid_d   = bus.read_en;
      fault_d      = (bus.read_en & bus.write_en) | (|(lane_we & lane_ro));
      rd_io_d      = rd_io_q;
      rd_io_byte_d = rd_io_byte_q;
      rd_swap_d    = rd_swap_q;
      if (bus.read_en) begin
         rd_io_d      = lane_io;
         rd_io_byte_d = lane_io_rd;
         rd_swap_d    = bus.address[0];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sw_s1_q      <= '0;
         sw_s2_q      <= '0;
         btn_s1_q     <= '0;
         btn_s2_q     <= '0;
         btn_prev_q   <= '0;
         btn_edge_q   <= '0;
         sseg_q       <= '0;
         led_q        <= '0;
         rd_valid_q   <= 1'b0;
         fault_q      <= 1'b0;
         rd_io_q      <= 2'b11;
         rd_io_byte_q <= '0;
         rd_swap_q    <= 1'b0;
      end else begin
         sw_s1_q      <= sw_s1_d;
         sw_s2_q      <= sw_s2_d;
         btn_s1_q     <= btn_s1_d;
         btn_s2_q     <= btn_s2_d;
         btn_prev_q   <= btn_prev_d;
         btn_edge_q   <= btn_edge_d;
         sseg_q       <= sseg_d;
         led_q        <= led_d;
         rd_valid_q   <= rd_valid_d;
         fault_q      <= fault_d;
         rd_io_q      <= rd_io_d;
         rd_io_byte_q <= rd_io_byte_d;
         rd_swap_q    <= rd_swap_d;
      end
   end

   // Even/odd banks let an unaligned 16-bit access touch two bytes in one cycle.
   assign a_odd      = bus.address[0];
   assign odd_idx    = bus.address[ADDR_W-1:1];
   assign even_idx   = a_odd ? lane_addr[0][ADDR_W-1:1] : lane_addr[1][ADDR_W-1:1];
   assign even_we    = a_odd ? lane_ram_we[0] : lane_ram_we[1];
   assign even_wdata = a_odd ? lane_wdata[0]  : lane_wdata[1];
   assign odd_we     = a_odd ? lane_ram_we[1] : lane_ram_we[0];
   assign odd_wdata  = a_odd ? lane_wdata[1]  : lane_wdata[0];

   always_ff @(posedge CLK) begin
      if (even_we) begin
         ram_even[even_idx] <= even_wdata;
      end
      if (bus.read_en) begin
         ram_even_rd_q <= ram_even[even_idx];
      end
   end

   always_ff @(posedge CLK) begin
      if (odd_we) begin
         ram_odd[odd_idx] <= odd_wdata;
      end
      if (bus.read_en) begin
         ram_odd_rd_q <= ram_odd[odd_idx];
      end
   end

   assign bus.output_data = {
      rd_io_q[1] ? rd_io_byte_q[15:8] : (rd_swap_q ? ram_odd_rd_q : ram_even_rd_q),
      rd_io_q[0] ? rd_io_byte_q[7:0]  : (rd_swap_q ? ram_even_rd_q : ram_odd_rd_q)
   };
   assign bus.read_valid   = rd_valid_q;
   assign bus.access_fault = fault_q;
   assign SSEG_VALUE       = sseg_q;
   assign LED              = led_q;
endmodule

// File: tb/tb_mmio_data_mem.sv
// Bench for mmio_data_mem: directed vector table, button/switch/reset sequences,
// then random traffic against a byte-level reference model.
module tb_mmio_data_mem;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [15:0] SW = '0;
   logic [4:0]  BTNS = '0;
   logic [31:0] SSEG_VALUE;
   logic [15:0] LED;

   mmio_data_mem_if #(.ADDR_W(8)) bus ();

   mmio_data_mem #(
      .ADDR_W(8), .IO_BASE('h40), .SW_W(16), .BTN_W(5)
   ) dut (
      .CLK(CLK), .RST(RST), .bus(bus), .SW(SW), .BTNS(BTNS),
      .SSEG_VALUE(SSEG_VALUE), .LED(LED)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit        rd;
      bit        wr;
      bit [1:0]  be;
      bit [7:0]  addr;
      bit [15:0] data;
      bit        exp_valid;
      bit        exp_fault;
      bit [15:0] exp_data;
   } vec_t;

   vec_t tbl[$];

   // Reference model state: plain byte array plus the I/O registers.
   logic [7:0]  mem_m [256];
   logic [31:0] sseg_m;
   logic [15:0] led_m;
   logic [15:0] sw_m;
   logic [7:0]  edge_m;
   logic [15:0] last_m;

   function automatic vec_t mk(bit rd, bit wr, bit [1:0] be, bit [7:0] a, bit [15:0] d,
                               bit ev, bit ef, bit [15:0] ed);
      vec_t v;
      v.rd = rd; v.wr = wr; v.be = be; v.addr = a; v.data = d;
      v.exp_valid = ev; v.exp_fault = ef; v.exp_data = ed;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input string tag, input bit rd, input bit wr, input bit [1:0] be,
                       input bit [7:0] a, input bit [15:0] d);
      bus.read_en    = rd;
      bus.write_en   = wr;
      bus.byte_en    = be;
      bus.address    = a;
      bus.input_data = d;
      @(posedge CLK);
      #1;
      bus.read_en  = 1'b0;
      bus.write_en = 1'b0;
      $display("txn %s rd=%0d wr=%0d be=%b a=%h d=%h -> valid=%0d fault=%0d data=%h sseg=%h led=%h",
               tag, rd, wr, be, a, d, bus.read_valid, bus.access_fault, bus.output_data,
               SSEG_VALUE, LED);
   endtask

   function automatic bit in_win(input logic [7:0] a);
      return (a >= 8'h40) && (a <= 8'h5F);
   endfunction

   function automatic bit is_ro(input logic [7:0] a);
      return (a >= 8'h4E) && (a <= 8'h53);
   endfunction

   function automatic logic [7:0] m_rd(input logic [7:0] a);
      logic [7:0] off;
      if (!in_win(a)) return mem_m[a];
      off = a - 8'h40;
      case (off)
         8'h00:   return sseg_m[31:24];
         8'h01:   return sseg_m[23:16];
         8'h02:   return sseg_m[15:8];
         8'h03:   return sseg_m[7:0];
         8'h04:   return led_m[15:8];
         8'h05:   return led_m[7:0];
         8'h0E:   return sw_m[15:8];
         8'h0F:   return sw_m[7:0];
         8'h13:   return edge_m;
         default: return 8'h00;
      endcase
   endfunction

   task automatic m_wr(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] off;
      if (!in_win(a)) begin
         mem_m[a] = b;
      end else begin
         off = a - 8'h40;
         case (off)
            8'h00:   sseg_m[31:24] = b;
            8'h01:   sseg_m[23:16] = b;
            8'h02:   sseg_m[15:8]  = b;
            8'h03:   sseg_m[7:0]   = b;
            8'h04:   led_m[15:8]   = b;
            8'h05:   led_m[7:0]    = b;
            default: ;
         endcase
      end
   endtask

   initial begin
      bus.read_en = 1'b0; bus.write_en = 1'b0; bus.byte_en = 2'b00;
      bus.address = '0;   bus.input_data = '0;

      repeat (2) @(posedge CLK);
      #1;
      chk("reset_data",  bus.output_data, 16'h0000);
      chk("reset_valid", bus.read_valid, 1'b0);
      chk("reset_fault", bus.access_fault, 1'b0);
      chk("reset_sseg",  SSEG_VALUE, 32'h0);
      chk("reset_led",   LED, 16'h0);
      RST = 1'b0;

      tbl.push_back(mk(0, 1, 2'b11, 8'h00, 16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(0, 1, 2'b11, 8'h10, 16'hBEEF, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 2'b00, 8'h10, 16'h0000, 1, 0, 16'hBEEF));
      tbl.push_back(mk(0, 0, 2'b00, 8'h00, 16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(0, 1, 2'b11, 8'h40, 16'h1234, 0, 0, 16'h0000));
      tbl.push_back(mk(0, 1, 2'b11, 8'h42, 16'h5678, 0, 0, 16'h0000));
      tbl.push_back(mk(0, 1, 2'b01, 8'h44, 16'hA5A5, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 2'b00, 8'h40, 16'h0000, 1, 0, 16'h1234));
      tbl.push_back(mk(1, 0, 2'b00, 8'h42, 16'h0000, 1, 0, 16'h5678));
      tbl.push_back(mk(1, 0, 2'b00, 8'h44, 16'h0000, 1, 0, 16'h00A5));
      tbl.push_back(mk(0, 1, 2'b11, 8'hFF, 16'hAA55, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 2'b00, 8'hFF, 16'h0000, 1, 0, 16'hAA55));
      tbl.push_back(mk(1, 0, 2'b00, 8'h00, 16'h0000, 1, 0, 16'h5500));
      tbl.push_back(mk(0, 1, 2'b11, 8'h20, 16'h2222, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 1, 2'b11, 8'h20, 16'h1111, 1, 1, 16'h2222));
      tbl.push_back(mk(1, 0, 2'b00, 8'h20, 16'h0000, 1, 0, 16'h2222));
      tbl.push_back(mk(0, 1, 2'b00, 8'h4E, 16'hFFFF, 0, 0, 16'h0000));
      tbl.push_back(mk(0, 1, 2'b11, 8'h46, 16'hBBBB, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 2'b00, 8'h46, 16'h0000, 1, 0, 16'h0000));
      tbl.push_back(mk(0, 1, 2'b01, 8'h52, 16'hFFFF, 0, 1, 16'h0000));
      tbl.push_back(mk(0, 0, 2'b00, 8'h00, 16'h0000, 0, 0, 16'h0000));
      tbl.push_back(mk(0, 1, 2'b10, 8'h10, 16'h7700, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 2'b00, 8'h10, 16'h0000, 1, 0, 16'h77EF));
      tbl.push_back(mk(0, 1, 2'b11, 8'h3E, 16'hCDCD, 0, 0, 16'h0000));
      tbl.push_back(mk(1, 0, 2'b00, 8'h3F, 16'h0000, 1, 0, 16'hCD12));

      foreach (tbl[i]) begin
         step($sformatf("vec%0d", i), tbl[i].rd, tbl[i].wr, tbl[i].be, tbl[i].addr, tbl[i].data);
         chk($sformatf("vec%0d_valid", i), bus.read_valid, tbl[i].exp_valid);
         chk($sformatf("vec%0d_fault", i), bus.access_fault, tbl[i].exp_fault);
         if (tbl[i].exp_valid) chk($sformatf("vec%0d_data", i), bus.output_data, tbl[i].exp_data);
      end
      chk("sseg_after_vec", SSEG_VALUE, 32'h12345678);
      chk("led_after_vec",  LED, 16'h00A5);

      // Switches: synchronised value, straddled read, rejected write.
      SW = 16'h0F0F;
      repeat (3) step("idle", 0, 0, 2'b00, 8'h00, 16'h0);
      step("sw_rd", 1, 0, 2'b00, 8'h4E, 16'h0);
      chk("sw_read", bus.output_data, 16'h0F0F);
      step("sw_rd_straddle", 1, 0, 2'b00, 8'h4F, 16'h0);
      chk("sw_read_straddle", bus.output_data, 16'h0F00);
      step("sw_wr", 0, 1, 2'b11, 8'h4E, 16'hFFFF);
      chk("sw_wr_fault", bus.access_fault, 1'b1);
      step("idle", 0, 0, 2'b00, 8'h00, 16'h0);
      chk("sw_fault_one_cycle", bus.access_fault, 1'b0);
      step("sw_rd", 1, 0, 2'b00, 8'h4E, 16'h0);
      chk("sw_read_after_wr", bus.output_data, 16'h0F0F);

      // Button edge capture and clear-on-read.
      BTNS = 5'b00100;
      repeat (4) step("idle", 0, 0, 2'b00, 8'h00, 16'h0);
      BTNS = 5'b00000;
      repeat (3) step("idle", 0, 0, 2'b00, 8'h00, 16'h0);
      step("edge_rd", 1, 0, 2'b00, 8'h52, 16'h0);
      chk("edge_first_read", bus.output_data, 16'h0004);
      step("edge_rd", 1, 0, 2'b00, 8'h52, 16'h0);
      chk("edge_cleared", bus.output_data, 16'h0000);

      // Pre-set bit 0, then land a BTNS[2] rise on the clearing read edge.
      BTNS = 5'b00001;
      repeat (2) step("idle", 0, 0, 2'b00, 8'h00, 16'h0);
      BTNS = 5'b00000;
      repeat (3) step("idle", 0, 0, 2'b00, 8'h00, 16'h0);
      BTNS = 5'b00100;
      step("idle", 0, 0, 2'b00, 8'h00, 16'h0);
      step("idle", 0, 0, 2'b00, 8'h00, 16'h0);
      step("edge_rd_race", 1, 0, 2'b00, 8'h52, 16'h0);
      chk("edge_race_data", bus.output_data, 16'h0001);
      step("edge_rd", 1, 0, 2'b00, 8'h52, 16'h0);
      chk("edge_set_wins", bus.output_data, 16'h0004);
      step("edge_rd", 1, 0, 2'b00, 8'h52, 16'h0);
      chk("edge_final_clear", bus.output_data, 16'h0000);
      BTNS = 5'b00000;

      // Reset during accesses: no read response, no commit, I/O back to 0.
      RST = 1'b1;
      step("rst_rd", 1, 0, 2'b00, 8'h10, 16'h0);
      chk("rst_valid", bus.read_valid, 1'b0);
      chk("rst_data",  bus.output_data, 16'h0000);
      chk("rst_sseg",  SSEG_VALUE, 32'h0);
      chk("rst_led",   LED, 16'h0);
      step("rst_wr", 0, 1, 2'b11, 8'h10, 16'hDEAD);
      chk("rst_fault", bus.access_fault, 1'b0);
      RST = 1'b0;
      step("idle", 0, 0, 2'b00, 8'h00, 16'h0);
      step("post_rst_rd", 1, 0, 2'b00, 8'h10, 16'h0);
      chk("ram_kept_over_rst", bus.output_data, 16'h77EF);

      // Random traffic against the byte-level model, starting from a zeroed RAM.
      for (int a = 0; a < 256; a += 2) step("fill", 0, 1, 2'b11, 8'(a), 16'h0000);
      for (int a = 0; a < 256; a++) mem_m[a] = 8'h00;
      sseg_m = '0; led_m = '0; sw_m = 16'h0F0F; edge_m = '0; last_m = 16'h77EF;

      for (int i = 0; i < 400; i++) begin
         int         op;
         bit         rd, wr, ef;
         bit [1:0]   be;
         bit [7:0]   a, a1;
         bit [15:0]  d;
         op = $urandom_range(0, 3);
         rd = (op == 1) || (op == 3);
         wr = (op >= 2);
         be = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 1) == 1) ? 8'(8'h30 + $urandom_range(0, 63)) : 8'($urandom_range(0, 255));
         a1 = a + 8'd1;
         d  = 16'($urandom);
         ef = (rd && wr) || (wr && ((be[1] && is_ro(a)) || (be[0] && is_ro(a1))));
         if (rd) begin
            last_m = {m_rd(a), m_rd(a1)};
            if (a == 8'h53 || a1 == 8'h53) edge_m = 8'h00;
         end
         if (wr && !rd) begin
            if (be[1]) m_wr(a, d[15:8]);
            if (be[0]) m_wr(a1, d[7:0]);
         end
         step($sformatf("rnd%0d", i), rd, wr, be, a, d);
         chk("rnd_valid", bus.read_valid, rd);
         chk("rnd_fault", bus.access_fault, ef);
         chk("rnd_data",  bus.output_data, last_m);
         chk("rnd_sseg",  SSEG_VALUE, sseg_m);
         chk("rnd_led",   LED, led_m);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mmio_data_mem.md
# mmio_data_mem

Byte-addressed data memory for the soft CPU with a relocatable memory-mapped I/O window. It serves 16-bit big-endian reads and writes with per-byte enables and a registered, one-cycle read latency. The I/O window holds synchronised switch/button inputs, sticky button-edge capture with clear-on-read, and output registers that drive the seven-segment value and LEDs. It sits between the CPU load/store stage and the board I/O.

## Interface
- ADDR_W, 8, byte-address width; the RAM holds 2**ADDR_W bytes.
- IO_BASE, 8'h40, base address of the 32-byte I/O window; must be a multiple of 32.
- SW_W, 16, switch count; at most 16.
- BTN_W, 5, button count; at most 8.

- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  byte address of the high byte; the low byte is at address+1.
- read_en  in  1  read request for this cycle.
- write_en  in  1  write request for this cycle.
- byte_en  in  2  bit1 enables the high byte (address); bit0 enables the low byte (address+1). Writes only.
- input_data  in  16  write data, big-endian.
- output_data  out  16  read data, registered.
- read_valid  out  1  one-cycle pulse: output_data has been updated.
- access_fault  out  1  one-cycle pulse: the request was fully or partly rejected.
- SW  in  SW_W  raw switches, asynchronous to CLK.
- BTNS  in  BTN_W  raw buttons, asynchronous to CLK.
- SSEG_VALUE  out  32  value for the seven-segment driver.
- LED  out  16  LED drive.

## Operation
- Byte addressing:
  - address+1 is computed modulo 2**ADDR_W, so the top address pairs with byte 0.
  - Each byte is decoded independently; one access may straddle RAM and I/O.
- The I/O window is IO_BASE..IO_BASE+31. Window bytes shadow RAM; RAM cells at those addresses are never read or written. Offsets:
  - 0x00-0x03: SSEG_VALUE[31:0], byte 0x00 = bits 31:24. Read/write.
  - 0x04-0x05: LED[15:8], LED[7:0]. Read/write.
  - 0x0E-0x0F: synchronised SW, zero-extended to 16 bits. Read-only.
  - 0x10-0x11: synchronised BTNS in 0x11, zero-extended; 0x10 reads 0. Read-only.
  - 0x12-0x13: BTN_EDGE sticky register in 0x13; 0x12 reads 0. Read clears it; writes are rejected.
  - All other window offsets read 0 and silently ignore writes. These do not fault.
- SW and BTNS pass through a two-flop synchroniser each. BTN_EDGE[i] sets on a 0->1 transition of synchronised BTNS[i].
- Reads:
  - read_en in cycle N: output_data and read_valid in cycle N+1.
  - output_data holds its last value whenever read_valid is 0.
  - A read that covers byte 0x13 clears BTN_EDGE at the same edge. If a new edge arrives on that same edge, its bit stays set (set wins), and the returned data excludes it.
- Writes:
  - Enabled bytes update at the edge ending cycle N.
  - A write to a read-only byte (0x0E-0x13) suppresses only that byte and pulses access_fault in N+1.
  - byte_en == 0 is a no-op with no fault.
- read_en and write_en both high: the read is performed, the write is dropped, and access_fault pulses in N+1.
- Read-after-write: a read in N+1 returns the data written in N.

## Timing
- Reset values:
  - output_data = 0, read_valid = 0, access_fault = 0.
  - SSEG_VALUE = 0, LED = 0, BTN_EDGE = 0, synchroniser flops = 0.
  - RAM is not reset. It is zero-initialised at configuration and keeps its contents across RST.
- RST asserted mid-access: the in-flight read_valid and access_fault are cancelled, and no byte commits on that edge.
- Input latency: an SW change is readable 2 cycles after it is sampled. A button press sets BTN_EDGE 3 edges after the raw rise.
- SSEG_VALUE and LED change on the same edge as the write that targets them.
- There is no backpressure; one request per cycle is sustained.

## Test plan
- Write 16'hBEEF to 8'h10 with byte_en=2'b11, then read 8'h10: output_data=16'hBEEF and read_valid=1 exactly one cycle after read_en.
- Write 16'h1234 to 8'h40 and then 16'h5678 to 8'h42: SSEG_VALUE=32'h12345678. Write 16'hA5A5 to 8'h44 with byte_en=2'b01: LED=16'h00A5.
- Write 16'hAA55 to 8'hFF with byte_en=2'b11: byte FF=8'hAA and byte 00=8'h55 (wrap-around). A subsequent read of 8'hFF returns 16'hAA55.
- SW=16'h0F0F, wait 3 cycles, read 8'h4E: output_data=16'h0F0F. Write 16'hFFFF to 8'h4E: access_fault=1 for one cycle, and a read still returns 16'h0F0F.
- Pulse BTNS[2] for 4 cycles, then read 8'h52: output_data=16'h0004. Read 8'h52 again: output_data=16'h0000. Repeat with a second BTNS[2] rise landing on the clearing read edge: the bit remains set for the next read.
- read_en and write_en high together with address 8'h20 and input_data 16'h1111: the read returns the old data, access_fault pulses, and memory is unchanged. Assert RST during a read: read_valid stays 0 and all I/O outputs return to 0.
